// File: rtl/block_emitter_pkg.sv
// Shared encodings for the block emitter: command ops, FSM states, keyword
// selectors, ASCII constants and keyword lengths.
package block_emitter_pkg;

  typedef enum logic [1:0] {
    OP_BEGIN     = 2'b00,
    OP_END       = 2'b01,
    OP_CHAR      = 2'b10,
    OP_CLOSE_ALL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KW    = 2'd1,
    S_SEP   = 2'd2,
    S_CLOSE = 2'd3
  } state_e;

  // KW_RAW marks a single CHAR byte travelling through the keyword state.
  typedef enum logic [1:0] {
    KW_BEGIN = 2'd0,
    KW_END   = 2'd1,
    KW_RAW   = 2'd2
  } kw_e;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_D     = 8'h64;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6e;

  localparam int KW_BEGIN_LEN = 5;
  localparam int KW_END_LEN   = 3;

  function automatic logic [2:0] kw_last_idx(kw_e kw);
    case (kw)
      KW_BEGIN: return 3'(KW_BEGIN_LEN - 1);
      KW_END:   return 3'(KW_END_LEN - 1);
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/block_emitter_if.sv
// Command and byte-output handshakes of the block emitter, bundled so the
// sequencer side (master) and the emitter (slave) share one port.
interface block_emitter_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_char;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_char;

  modport master (
    output cmd_valid, cmd_op, cmd_char, out_ready,
    input  cmd_ready, out_valid, out_char
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_char, out_ready,
    output cmd_ready, out_valid, out_char
  );

endinterface

// File: rtl/block_kw_rom.sv
// Combinational keyword lookup: returns the idx-th letter of "begin" or "end",
// 8'h00 outside the keyword.
module block_kw_rom
  import block_emitter_pkg::*;
(
  input  kw_e        kw_i,
  input  logic [2:0] idx_i,
  output logic [7:0] char_o
);

  always_comb begin
    char_o = 8'h00;
    case (kw_i)
      KW_BEGIN: begin
        case (idx_i)
          3'd0:    char_o = CH_B;
          3'd1:    char_o = CH_E;
          3'd2:    char_o = CH_G;
          3'd3:    char_o = CH_I;
          3'd4:    char_o = CH_N;
          default: char_o = 8'h00;
        endcase
      end
      KW_END: begin
        case (idx_i)
          3'd0:    char_o = CH_E;
          3'd1:    char_o = CH_N;
          3'd2:    char_o = CH_D;
          default: char_o = 8'h00;
        endcase
      end
      default: char_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/block_emitter.sv
// Turns BEGIN/END/CHAR/CLOSE_ALL commands into an ASCII byte stream and tracks
// nesting depth. Define BLOCK_EMITTER_AUTO_SPACE_EN to append a space after every keyword.
module block_emitter
  import block_emitter_pkg::*;
#(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  block_emitter_if.slave     bus,
  output logic [DEPTH_W-1:0] depth,
  output logic               underflow,
  output logic               overflow,
  output logic               balanced
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_e             state_q;
  kw_e                kw_q;
  logic [2:0]         idx_q;
  logic               out_valid_q;
  logic [7:0]         out_char_q;
  logic [DEPTH_W-1:0] depth_q;
  logic               underflow_q;
  logic               overflow_q;
`ifdef BLOCK_EMITTER_AUTO_SPACE_EN
  logic               sep_to_close_q;
`endif

  op_e        op_d;
  kw_e        rom_kw_d;
  logic [2:0] rom_idx_d;
  logic [7:0] rom_char;
  logic       hs_d;
  logic       kw_done_d;
  logic       close_last_d;

  assign op_d         = op_e'(bus.cmd_op);
  assign hs_d         = out_valid_q && bus.out_ready;
  assign kw_done_d    = (kw_q == KW_RAW) || (idx_q == kw_last_idx(kw_q));
  assign close_last_d = (depth_q <= DEPTH_W'(1));

  // In IDLE the ROM supplies the first letter of the incoming keyword;
  // otherwise it supplies the letter after the one currently on the output.
  always_comb begin
    rom_kw_d  = KW_END;
    rom_idx_d = idx_q + 3'd1;
    if (state_q == S_IDLE) begin
      rom_kw_d  = (op_d == OP_BEGIN) ? KW_BEGIN : KW_END;
      rom_idx_d = 3'd0;
    end else if (state_q == S_KW) begin
      rom_kw_d  = kw_q;
    end
  end

  block_kw_rom u_kw_rom (
    .kw_i   (rom_kw_d),
    .idx_i  (rom_idx_d),
    .char_o (rom_char)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      kw_q           <= KW_BEGIN;
      idx_q          <= 3'd0;
      out_valid_q    <= 1'b0;
      out_char_q     <= 8'h00;
      depth_q        <= '0;
      underflow_q    <= 1'b0;
      overflow_q     <= 1'b0;
`ifdef BLOCK_EMITTER_AUTO_SPACE_EN
      sep_to_close_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            idx_q <= 3'd0;
            case (op_d)
              OP_BEGIN: begin
                kw_q        <= KW_BEGIN;
                out_valid_q <= 1'b1;
                out_char_q  <= rom_char;
                state_q     <= S_KW;
                if (depth_q == DEPTH_MAX) overflow_q <= 1'b1;
                else                      depth_q    <= depth_q + DEPTH_W'(1);
              end
              OP_END: begin
                kw_q        <= KW_END;
                out_valid_q <= 1'b1;
                out_char_q  <= rom_char;
                state_q     <= S_KW;
                if (depth_q == '0) underflow_q <= 1'b1;
                else               depth_q     <= depth_q - DEPTH_W'(1);
              end
              OP_CHAR: begin
                kw_q        <= KW_RAW;
                out_valid_q <= 1'b1;
                out_char_q  <= bus.cmd_char;
                state_q     <= S_KW;
              end
              default: begin
                // CLOSE_ALL with nothing open is a silent no-op.
                if (depth_q != '0) begin
                  out_valid_q <= 1'b1;
                  out_char_q  <= CH_E;
                  state_q     <= S_CLOSE;
                end
              end
            endcase
          end
        end

        S_KW: begin
          if (hs_d) begin
            if (kw_done_d) begin
`ifdef BLOCK_EMITTER_AUTO_SPACE_EN
              if (kw_q != KW_RAW) begin
                out_char_q     <= CH_SPACE;
                sep_to_close_q <= 1'b0;
                state_q        <= S_SEP;
              end else begin
                out_valid_q <= 1'b0;
                state_q     <= S_IDLE;
              end
`else
              out_valid_q <= 1'b0;
              state_q     <= S_IDLE;
`endif
            end else begin
              idx_q      <= idx_q + 3'd1;
              out_char_q <= rom_char;
            end
          end
        end

        S_CLOSE: begin
          if (hs_d) begin
            if (idx_q == 3'(KW_END_LEN - 1)) begin
              // Each completed "end" closes one block.
              if (depth_q != '0) depth_q <= depth_q - DEPTH_W'(1);
`ifdef BLOCK_EMITTER_AUTO_SPACE_EN
              out_char_q     <= CH_SPACE;
              sep_to_close_q <= !close_last_d;
              state_q        <= S_SEP;
`else
              if (close_last_d) begin
                out_valid_q <= 1'b0;
                state_q     <= S_IDLE;
              end else begin
                idx_q      <= 3'(KW_END_LEN);
                out_char_q <= CH_SPACE;
              end
`endif
            end else if (idx_q == 3'(KW_END_LEN)) begin
              // Separator between consecutive ends has been taken.
              idx_q      <= 3'd0;
              out_char_q <= CH_E;
            end else begin
              idx_q      <= idx_q + 3'd1;
              out_char_q <= rom_char;
            end
          end
        end

`ifdef BLOCK_EMITTER_AUTO_SPACE_EN
        S_SEP: begin
          if (hs_d) begin
            if (sep_to_close_q) begin
              idx_q      <= 3'd0;
              out_char_q <= CH_E;
              state_q    <= S_CLOSE;
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
        end
`endif

        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_char  = out_char_q;
  assign depth         = depth_q;
  assign underflow     = underflow_q;
  assign overflow      = overflow_q;
  assign balanced      = (depth_q == '0) && !underflow_q && !overflow_q;

endmodule

// File: tb/tb_block_emitter.sv
// Scoreboard bench for block_emitter: stimulus pushes expected bytes, a monitor
// pops and compares on every output handshake. Uses a 2-bit depth counter.
module tb_block_emitter;
  import block_emitter_pkg::*;

  localparam int DW = 2;
`ifdef BLOCK_EMITTER_AUTO_SPACE_EN
  localparam int AS = 1;
`else
  localparam int AS = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] depth;
  logic          underflow;
  logic          overflow;
  logic          balanced;

  block_emitter_if bif ();

  block_emitter #(.DEPTH_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif.slave),
    .depth     (depth),
    .underflow (underflow),
    .overflow  (overflow),
    .balanced  (balanced)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         hs_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_str(string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_kw(string k);
    push_str(k);
    if (AS != 0) push_str(" ");
  endtask

  task automatic push_close(int n);
    for (int i = 0; i < n; i++) begin
      push_str("end");
      if (AS != 0 || i != n - 1) push_str(" ");
    end
  endtask

  // Monitor: one line per accepted output byte.
  always @(negedge clk) begin
    if (!reset && bif.out_valid && bif.out_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream: got unexpected byte 0x%02h, expected none", bif.out_char);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("byte %0d: got 0x%02h expected 0x%02h depth=%0d", hs_count, bif.out_char, mon_exp, depth);
        check("stream", int'(bif.out_char), int'(mon_exp));
      end
    end
  end

  task automatic wait_idle(string name);
    int n = 0;
    @(negedge clk);
    while (!bif.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready_timeout"}, int'(bif.cmd_ready), 1);
  endtask

  task automatic send(logic [1:0] op, logic [7:0] ch);
    wait_idle("send");
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = op;
    bif.cmd_char  = ch;
    $display("cmd op=%0d char=0x%02h depth=%0d", op, ch, depth);
    @(posedge clk);
    #1;
    bif.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs0;
    int exp_d;
    int n;
    bif.cmd_valid = 1'b0;
    bif.cmd_op    = 2'b00;
    bif.cmd_char  = 8'h00;
    bif.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", int'(bif.out_valid), 0);
    check("rst_out_char", int'(bif.out_char), 0);
    check("rst_depth", int'(depth), 0);
    check("rst_flags", int'({underflow, overflow}), 0);
    check("rst_balanced", int'(balanced), 1);
    check("rst_cmd_ready", int'(bif.cmd_ready), 1);

    // BEGIN latency and cmd_ready timing
    push_kw("begin");
    send(OP_BEGIN, 8'h00);
    @(negedge clk);
    check("begin_first_valid", int'(bif.out_valid), 1);
    check("begin_first_char", int'(bif.out_char), 8'h62);
    check("begin_depth", int'(depth), 1);
    check("begin_busy", int'(bif.cmd_ready), 0);
    repeat (4 + AS) @(negedge clk);
    check("begin_last_busy", int'(bif.cmd_ready), 0);
    @(negedge clk);
    check("begin_done_ready", int'(bif.cmd_ready), 1);
    check("begin_done_valid", int'(bif.out_valid), 0);

    // " x end" completes "begin x end"
    push_str(" x ");
    push_kw("end");
    send(OP_CHAR, 8'h20);
    send(OP_CHAR, 8'h78);
    send(OP_CHAR, 8'h20);
    send(OP_END, 8'h00);
    wait_idle("bxe");
    check("bxe_depth", int'(depth), 0);
    check("bxe_balanced", int'(balanced), 1);

    // three BEGINs then CLOSE_ALL
    for (int i = 0; i < 3; i++) begin
      push_kw("begin");
      send(OP_BEGIN, 8'h00);
    end
    wait_idle("nest");
    check("nest_depth", int'(depth), 3);
    check("nest_overflow", int'(overflow), 0);
    push_close(3);
    send(OP_CLOSE_ALL, 8'h00);
    exp_d = 3;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (bif.cmd_ready) break;
      if (bif.out_valid && bif.out_ready && bif.out_char == 8'h64) begin
        @(negedge clk);
        exp_d--;
        check("close_depth_step", int'(depth), exp_d);
      end
    end
    check("close_ready", int'(bif.cmd_ready), 1);
    check("close_d_count", exp_d, 0);
    check("close_balanced", int'(balanced), 1);

    // CLOSE_ALL at depth 0 emits nothing
    hs0 = hs_count;
    send(OP_CLOSE_ALL, 8'h00);
    repeat (3) @(negedge clk);
    check("close0_ready", int'(bif.cmd_ready), 1);
    check("close0_no_bytes", hs_count - hs0, 0);
    check("close0_underflow", int'(underflow), 0);

    // END at depth 0: underflow sticky
    push_kw("end");
    send(OP_END, 8'h00);
    wait_idle("uf");
    check("uf_flag", int'(underflow), 1);
    check("uf_depth", int'(depth), 0);
    check("uf_balanced", int'(balanced), 0);
    push_kw("begin");
    push_kw("end");
    send(OP_BEGIN, 8'h00);
    send(OP_END, 8'h00);
    wait_idle("uf2");
    check("uf_sticky", int'(underflow), 1);
    check("uf_sticky_balanced", int'(balanced), 0);

    // back-pressure during BEGIN: ready 1,0,0,1
    hs0 = hs_count;
    push_kw("begin");
    send(OP_BEGIN, 8'h00);
    @(negedge clk);
    check("bp_b", int'(bif.out_char), 8'h62);
    @(posedge clk); #1; bif.out_ready = 1'b0;
    @(negedge clk);
    check("bp_hold1", int'(bif.out_char), 8'h65);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_hold2", int'(bif.out_char), 8'h65);
    check("bp_hold2_valid", int'(bif.out_valid), 1);
    @(posedge clk); #1; bif.out_ready = 1'b1;
    @(negedge clk);
    check("bp_hold3", int'(bif.out_char), 8'h65);
    wait_idle("bp");
    check("bp_handshakes", hs_count - hs0, 5 + AS);
    push_kw("end");
    send(OP_END, 8'h00);
    wait_idle("bp_end");

    // overflow at max depth, then async reset mid-keyword
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_kw("begin");
      send(OP_BEGIN, 8'h00);
    end
    wait_idle("ovf");
    check("ovf_pre_depth", int'(depth), 3);
    check("ovf_pre_flag", int'(overflow), 0);
    push_kw("begin");
    send(OP_BEGIN, 8'h00);
    @(negedge clk);
    check("ovf_depth_sat", int'(depth), 3);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_balanced", int'(balanced), 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("arst_out_valid", int'(bif.out_valid), 0);
    check("arst_depth", int'(depth), 0);
    check("arst_flags", int'({underflow, overflow}), 0);
    check("arst_ready", int'(bif.cmd_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    push_kw("end");
    send(OP_END, 8'h00);
    wait_idle("post_rst");
    check("post_rst_underflow", int'(underflow), 1);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_emitter.md
Name: block_emitter

Overview:
- Transmit-side counterpart of the begin/end nesting checker.
- Converts a command stream (BEGIN, END, raw CHAR, CLOSE_ALL) into an ASCII byte stream, one character per accepted output beat.
- Tracks nesting depth and flags unbalanced usage, so generated streams can drive the checker directly in self-checking benches.
- Sits between the test/sequence logic and any byte-serial consumer.

Parameters:
- DEPTH_W, 8, width of nesting-depth counter; max depth 2^DEPTH_W-1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 BEGIN, 01 END, 10 CHAR, 11 CLOSE_ALL.
- cmd_char  in  8  byte emitted for CHAR; ignored otherwise.
- out_valid  out  1  out_char valid.
- out_ready  in  1  consumer takes byte when out_valid && out_ready.
- out_char  out  8  emitted ASCII byte.
- depth  out  DEPTH_W  current open-block count.
- underflow  out  1  sticky: END/close seen at depth 0.
- overflow  out  1  sticky: BEGIN seen at max depth.
- balanced  out  1  combinational: depth==0 && !underflow && !overflow.

Behaviour:
- Reset values: out_valid=0, out_char=8'h00, depth=0, underflow=0, overflow=0, state IDLE. Reset mid-keyword aborts it; no partial continuation.
- cmd_ready = (state==IDLE). It is 0 while any character of a command is pending.
- States:
  - IDLE: waits for a command.
  - KW: emits the keyword at index idx (3 bits).
  - SEP: auto-space; exists only with the optional feature.
  - CLOSE: loops END emission until depth reaches 0.
- Latency: the first character of a command is valid on the cycle after acceptance. Subsequent characters follow on consecutive cycles while out_ready=1.
- Output hold: while out_valid && !out_ready, out_char and out_valid are held stable. idx advances only on an output handshake.
- BEGIN:
  - Emits lowercase "b","e","g","i","n".
  - depth increments at acceptance.
  - At depth==max: overflow is set and depth saturates. The characters are still emitted.
- END:
  - Emits "e","n","d".
  - depth decrements at acceptance.
  - At depth==0: underflow is set, depth stays 0, and the characters are still emitted.
- CHAR: emits cmd_char once, raw, with no case change, then returns to IDLE.
- CLOSE_ALL:
  - At depth==0: accepted, emits nothing, returns to IDLE the next cycle. underflow is not set.
  - Otherwise: emits "end" repeatedly. depth decrements on each handshake of the final 'd'. Returns to IDLE after the 'd' that brings depth to 0.
  - Without auto-space, consecutive ends are separated by a single space byte 8'h20. There is no space after the last one.
- Returning to IDLE: after the last handshake, out_valid drops to 0 the next cycle and cmd_ready rises the same cycle. There is no back-to-back overlap of commands.
- Depth arithmetic is unsigned DEPTH_W-bit. Wrap-around is never allowed; the counter saturates and the sticky flag is set instead.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: BLOCK_EMITTER_AUTO_SPACE_EN.
- Defined:
  - After every BEGIN or END keyword (including each within CLOSE_ALL), the SEP state emits one 8'h20 before returning to IDLE or continuing.
  - CLOSE_ALL uses only these auto-spaces.
  - CHAR never gets an auto-space.
- Undefined: the SEP state and its logic are absent. Keywords are not separated automatically; the user emits separators via CHAR.

Decomposition:
- Package block_emitter_pkg holds:
  - cmd_op encodings: OP_BEGIN, OP_END, OP_CHAR, OP_CLOSE_ALL.
  - State encodings: S_IDLE, S_KW, S_SEP, S_CLOSE.
  - ASCII constants: space and keyword letters.
  - Keyword lengths: 5 for begin, 3 for end.
- One sub-module is natural: block_kw_rom.
  - Combinational.
  - Inputs: kw select (begin/end) and idx[2:0].
  - Output: char[7:0].

Test Plan:
- Reset, then BEGIN with out_ready=1 -> out_char "b","e","g","i","n" on cycles 1-5; depth=1 from cycle 1; cmd_ready=1 on cycle 6.
- Sequence BEGIN, CHAR 8'h20, CHAR "x", CHAR 8'h20, END (no auto-space) -> stream "begin x end"; depth returns to 0; balanced=1. Feed the stream to the checker: result=1.
- BEGIN, BEGIN, BEGIN, CLOSE_ALL (auto-space defined) -> stream "begin begin begin end end end "; depth steps 3→2→1→0 on each 'd' handshake.
- END at depth 0 -> "end" emitted; underflow=1 sticky; depth=0; balanced=0 persists through a later BEGIN/END pair until reset.
- out_ready toggled 1,0,0,1 during BEGIN -> 'e' held on out_char for 3 cycles; no byte lost or duplicated; total 5 handshakes.
- DEPTH_W=2: four BEGINs -> depth saturates at 3; overflow=1. Assert reset during the 4th keyword -> out_valid=0, depth=0, flags=0 immediately.
